irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter NUM_SRC, default 5: number of interrupt sources, legal range 1..8.
REQ-002 SHALL have parameter VEC_BASE, default 16'h0040: vector of source 0.
REQ-003 SHALL have parameter VEC_STRIDE, default 8: vector spacing between consecutive sources.
REQ-004 SHALL have parameters ADDR_IF, default 16'hFF0F, and ADDR_IE, default 16'hFFFF: register addresses.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset (asserted when 0, sampled on posedge clk).
REQ-007 SHALL have port bus, Bus_if.Peripheral_side: addr/wdata/write_en/read_en/rdata register access.
REQ-008 SHALL have port req, input, NUM_SRC: per-source request; bit 0 has the highest priority.
REQ-009 SHALL have port instr_boundary, input, 1: the CPU finished an instruction this cycle.
REQ-010 SHALL have ports ei_req and di_req, input, 1 each: the CPU executed EI or DI.
REQ-011 SHALL have port irq_valid, output, 1: a dispatch is offered.
REQ-012 SHALL have port irq_index, output, 3: the offered source.
REQ-013 SHALL have port irq_vector, output, 16: equals VEC_BASE + irq_index*VEC_STRIDE.
REQ-014 SHALL have port irq_ack, input, 1: the CPU accepts the offer.
REQ-015 SHALL have port wake, output, 1: combinational |(IF & IE) over the NUM_SRC bits, independent of IME; used for HALT exit.
REQ-016 SHALL have port ime, output, 1: the master enable.

Function
REQ-017 SHALL write IF[NUM_SRC-1:0] from wdata on a write to ADDR_IF; IF bits at or above NUM_SRC SHALL read as 1.
REQ-018 SHALL store all 8 bits of IE on a write to ADDR_IE.
REQ-019 SHALL drive rdata combinationally with IF or IE when read_en is high and addr matches, else 8'h00.
REQ-020 SHALL set IF[i] when the qualified req[i] is high; a set SHALL win over a bus write or ack clear in the same cycle.
REQ-021 SHALL make di_req clear IME and cancel any pending EI next cycle.
REQ-022 SHALL arm an EI delay on ei_req; IME SHALL become 1 on the second instr_boundary after ei_req, so the instruction following EI completes first.
REQ-023 SHALL implement an FSM IDLE -> OFFER -> IDLE.
REQ-024 In IDLE, SHALL move to OFFER next cycle when instr_boundary && IME && pending!=0, latching irq_index as the lowest set bit of IF&IE.
REQ-025 In OFFER, SHALL hold irq_valid=1 and keep index/vector frozen, even if a higher-priority source arrives.
REQ-026 In OFFER with irq_ack=1, SHALL clear IF[irq_index], clear IME, cancel any EI delay, and return to IDLE with irq_valid=0 next cycle.
REQ-027 In OFFER with IF[irq_index] or IE[irq_index] cleared by the bus and no ack, SHALL withdraw: return to IDLE with irq_valid=0.
REQ-028 SHALL ignore irq_ack in IDLE.
REQ-029 SHALL have a minimum latency of 1 cycle from the qualifying instr_boundary to irq_valid.

Reset
REQ-030 On reset=0, SHALL set IF[NUM_SRC-1:0]=0, IE=8'h00, IME=0, clear the EI delay, set state=IDLE, and drive irq_valid=0, irq_index=0, irq_vector=VEC_BASE.
REQ-031 Reset asserted in OFFER SHALL abort the offer with no IF clear.

Configuration
REQ-032 With IRQ_EDGE_DETECT_EN defined, req SHALL be treated as a level and a registered rising-edge detector (previous sample reset to 0) SHALL qualify the set.
REQ-033 Without IRQ_EDGE_DETECT_EN, req SHALL be treated as a single-cycle pulse and each high cycle SHALL set IF.

Structure
REQ-034 The irq_state_t enum, IRQ_MAX_SRC=8, and the default address constants SHALL live in cpu_types_pkg.
REQ-035 The lowest-set-bit priority encoder SHALL be a sub-module irq_prio_enc #(N).

Verification
REQ-036 SHALL verify: IE=8'h05, req pulses bits 2 and 0 together, IME=1, instr_boundary -> irq_valid=1, irq_index=0, irq_vector=16'h0040; ack -> IF reads 8'hE4, ime=0.
REQ-037 SHALL verify: ei_req, then two instr_boundary pulses -> ime=0 after the first and ime=1 after the second; di_req between them -> ime stays 0.
REQ-038 SHALL verify: IME=0, IE=8'h04, req[2] -> wake=1 and irq_valid stays 0.
REQ-039 SHALL verify: in OFFER with index 2, bus writes IF=8'h00 -> irq_valid=0 next cycle and state IDLE.
REQ-040 SHALL verify: bus write IF=8'h00 while req[1] is high in the same cycle -> IF reads 8'hE2.
REQ-041 SHALL verify: NUM_SRC=8, VEC_STRIDE=16, index 7 -> irq_vector=16'h00B0; reset=0 mid-OFFER -> irq_valid=0 and IF unchanged except cleared by reset.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and default constants for the CPU interrupt subsystem.
package cpu_types_pkg;

  localparam int          IRQ_MAX_SRC  = 8;
  localparam logic [15:0] DEF_ADDR_IF  = 16'hFF0F;
  localparam logic [15:0] DEF_ADDR_IE  = 16'hFFFF;
  localparam logic [15:0] DEF_VEC_BASE = 16'h0040;

  typedef enum logic {
    IRQ_IDLE,
    IRQ_OFFER
  } irq_state_t;

  // EI takes effect only after the instruction following it has completed.
  typedef enum logic [1:0] {
    EI_OFF,
    EI_WAIT1,
    EI_WAIT2
  } ei_state_t;

endpackage

// File: rtl/bus_if.sv
// Simple byte-wide register bus between the CPU and its memory-mapped peripherals.
interface Bus_if;

  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        write_en;
  logic        read_en;
  logic [7:0]  rdata;

  modport Peripheral_side (input addr, input wdata, input write_en, input read_en, output rdata);
  modport Host_side       (output addr, output wdata, output write_en, output read_en, input rdata);

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 is the highest priority.
module irq_prio_enc
  import cpu_types_pkg::*;
#(
  parameter int N = IRQ_MAX_SRC
) (
  input  logic [N-1:0] vec_i,
  output logic [2:0]   idx_o,
  output logic         any_o
);

  always_comb begin
    idx_o = 3'd0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = 3'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller with IF/IE registers, delayed EI, and a single-offer dispatch FSM.
// Define IRQ_EDGE_DETECT_EN to treat req as a level qualified by a rising-edge detector.
module irq_controller
  import cpu_types_pkg::*;
#(
  parameter int          NUM_SRC    = 5,
  parameter logic [15:0] VEC_BASE   = DEF_VEC_BASE,
  parameter int          VEC_STRIDE = 8,
  parameter logic [15:0] ADDR_IF    = DEF_ADDR_IF,
  parameter logic [15:0] ADDR_IE    = DEF_ADDR_IE
) (
  input  logic               clk,
  input  logic               reset,
  Bus_if.Peripheral_side     bus,
  input  logic [NUM_SRC-1:0] req,
  input  logic               instr_boundary,
  input  logic               ei_req,
  input  logic               di_req,
  output logic               irq_valid,
  output logic [2:0]         irq_index,
  output logic [15:0]        irq_vector,
  input  logic               irq_ack,
  output logic               wake,
  output logic               ime
);

  logic [NUM_SRC-1:0] if_q, if_d, set_req, pending;
  logic [7:0]         ie_q, ie_d, if_rd, if_d_ext, clr_mask;
  logic               ime_q, ime_d;
  ei_state_t          ei_q, ei_d;
  irq_state_t         state_q, state_d;
  logic [2:0]         idx_q, idx_d, enc_idx;
  logic               enc_any, wr_if, wr_ie, ack_take;

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] req_prev_q;

  always_ff @(posedge clk) begin
    if (!reset) req_prev_q <= '0;
    else        req_prev_q <= req;
  end

  assign set_req = req & ~req_prev_q;
`else
  assign set_req = req;
`endif

  assign wr_if    = bus.write_en && (bus.addr == ADDR_IF);
  assign wr_ie    = bus.write_en && (bus.addr == ADDR_IE);
  assign ack_take = (state_q == IRQ_OFFER) && irq_ack;
  assign clr_mask = 8'h01 << idx_q;
  assign pending  = if_q & ie_q[NUM_SRC-1:0];

  irq_prio_enc #(.N(NUM_SRC)) u_prio (
    .vec_i (pending),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // A hardware request always wins over a bus write or an ack clear.
  always_comb begin
    if_d = if_q;
    if (wr_if)    if_d = bus.wdata[NUM_SRC-1:0];
    if (ack_take) if_d = if_d & ~clr_mask[NUM_SRC-1:0];
    if_d = if_d | set_req;
    ie_d = wr_ie ? bus.wdata : ie_q;
    if_rd = 8'hFF;
    if_rd[NUM_SRC-1:0] = if_q;
    if_d_ext = 8'hFF;
    if_d_ext[NUM_SRC-1:0] = if_d;
  end

  always_comb begin
    ime_d = ime_q;
    ei_d  = ei_q;
    if (instr_boundary) begin
      if (ei_q == EI_WAIT2) begin
        ime_d = 1'b1;
        ei_d  = EI_OFF;
      end else if (ei_q == EI_WAIT1) begin
        ei_d = EI_WAIT2;
      end
    end
    if (ei_req) ei_d = EI_WAIT1;
    if (di_req || ack_take) begin
      ime_d = 1'b0;
      ei_d  = EI_OFF;
    end
  end

  // Withdrawal looks at next-cycle IF/IE so the offer drops as the bus clear lands.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IRQ_IDLE: begin
        if (instr_boundary && ime_q && enc_any) begin
          state_d = IRQ_OFFER;
          idx_d   = enc_idx;
        end
      end
      IRQ_OFFER: begin
        if (irq_ack || !if_d_ext[idx_q] || !ie_d[idx_q]) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if_q    <= '0;
      ie_q    <= 8'h00;
      ime_q   <= 1'b0;
      ei_q    <= EI_OFF;
      state_q <= IRQ_IDLE;
      idx_q   <= 3'd0;
    end else begin
      if_q    <= if_d;
      ie_q    <= ie_d;
      ime_q   <= ime_d;
      ei_q    <= ei_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.rdata  = !bus.read_en              ? 8'h00 :
                      (bus.addr == ADDR_IF)     ? if_rd :
                      (bus.addr == ADDR_IE)     ? ie_q  : 8'h00;
  assign irq_valid  = (state_q == IRQ_OFFER);
  assign irq_index  = idx_q;
  assign irq_vector = VEC_BASE + 16'(VEC_STRIDE) * {13'd0, idx_q};
  assign wake       = |pending;
  assign ime        = ime_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed table-driven bench for irq_controller (default build and an 8-source variant).
module tb_irq_controller;

  localparam logic [15:0] A_IF = 16'hFF0F;
  localparam logic [15:0] A_IE = 16'hFFFF;

  logic clk;
  logic rst_a, rst_b;
  logic [4:0] req_a;
  logic [7:0] req_b;
  logic ib_a, ei_a, di_a, ack_a, ib_b, ei_b, di_b, ack_b;
  logic irq_valid_a, wake_a, ime_a, irq_valid_b, wake_b, ime_b;
  logic [2:0] idx_a, idx_b;
  logic [15:0] vec_a, vec_b;

  int errors = 0;
  int checks = 0;

  Bus_if bus_a();
  Bus_if bus_b();

  irq_controller dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a), .req(req_a),
    .instr_boundary(ib_a), .ei_req(ei_a), .di_req(di_a),
    .irq_valid(irq_valid_a), .irq_index(idx_a), .irq_vector(vec_a),
    .irq_ack(ack_a), .wake(wake_a), .ime(ime_a)
  );

  irq_controller #(.NUM_SRC(8), .VEC_STRIDE(16)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b), .req(req_b),
    .instr_boundary(ib_b), .ei_req(ei_b), .di_req(di_b),
    .irq_valid(irq_valid_b), .irq_index(idx_b), .irq_vector(vec_b),
    .irq_ack(ack_b), .wake(wake_b), .ime(ime_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic [1:0]  wr;    // 0 none, 1 IF, 2 IE
    logic [7:0]  wd;
    logic [7:0]  rq;
    logic        ib, ei, di, ack;
    logic        rsel;  // 0 read IF, 1 read IE
    logic        ev;
    logic [2:0]  eidx;
    logic [15:0] evec;
    logic        eime, ewake;
    logic [7:0]  erd;
  } vec_t;

  vec_t tbl [30];

  task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic apply_a(input vec_t v, input int r);
    rst_a          = v.rstn;
    bus_a.write_en = (v.wr != 2'd0);
    bus_a.addr     = (v.wr == 2'd2) ? A_IE : A_IF;
    bus_a.wdata    = v.wd;
    req_a          = v.rq[4:0];
    ib_a = v.ib; ei_a = v.ei; di_a = v.di; ack_a = v.ack;
    @(posedge clk); #1;
    bus_a.write_en = 1'b0; req_a = 5'd0;
    ib_a = 1'b0; ei_a = 1'b0; di_a = 1'b0; ack_a = 1'b0;
    bus_a.read_en = 1'b1;
    bus_a.addr    = v.rsel ? A_IE : A_IF;
    #1;
    chk("irq_valid", r, {15'd0, irq_valid_a}, {15'd0, v.ev});
    chk("irq_index", r, {13'd0, idx_a}, {13'd0, v.eidx});
    chk("irq_vector", r, vec_a, v.evec);
    chk("ime", r, {15'd0, ime_a}, {15'd0, v.eime});
    chk("wake", r, {15'd0, wake_a}, {15'd0, v.ewake});
    chk(v.rsel ? "rdata_IE" : "rdata_IF", r, {8'd0, bus_a.rdata}, {8'd0, v.erd});
    bus_a.read_en = 1'b0;
  endtask

  task automatic step_b(input logic rstn, input logic [1:0] wr, input logic [7:0] wd,
                        input logic [7:0] rq, input logic ib, input logic ei);
    rst_b          = rstn;
    bus_b.write_en = (wr != 2'd0);
    bus_b.addr     = (wr == 2'd2) ? A_IE : A_IF;
    bus_b.wdata    = wd;
    req_b = rq; ib_b = ib; ei_b = ei;
    @(posedge clk); #1;
    bus_b.write_en = 1'b0; req_b = 8'd0; ib_b = 1'b0; ei_b = 1'b0;
  endtask

  task automatic read_b(input logic [15:0] addr, output logic [7:0] val);
    bus_b.read_en = 1'b1;
    bus_b.addr    = addr;
    #1;
    val = bus_b.rdata;
    bus_b.read_en = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    rst_a = 1'b0; rst_b = 1'b0;
    req_a = 5'd0; req_b = 8'd0;
    ib_a = 1'b0; ei_a = 1'b0; di_a = 1'b0; ack_a = 1'b0;
    ib_b = 1'b0; ei_b = 1'b0; di_b = 1'b0; ack_b = 1'b0;
    bus_a.addr = 16'd0; bus_a.wdata = 8'd0; bus_a.write_en = 1'b0; bus_a.read_en = 1'b0;
    bus_b.addr = 16'd0; bus_b.wdata = 8'd0; bus_b.write_en = 1'b0; bus_b.read_en = 1'b0;

    //         rstn  wr    wd     rq     ib    ei    di    ack   rsel   ev    idx   vec        ime   wake  rd
    tbl[0]  = '{1'b0,2'd0,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0040,1'b0,1'b0,8'hE0};
    tbl[1]  = '{1'b0,2'd0,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,3'd0,16'h0040,1'b0,1'b0,8'h00};
    tbl[2]  = '{1'b1,2'd2,8'h05,8'h00,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,3'd0,16'h0040,1'b0,1'b0,8'h05};
    tbl[3]  = '{1'b1,2'd0,8'h00,8'h05,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0040,1'b0,1'b1,8'hE5};
    tbl[4]  = '{1'b1,2'd0,8'h00,8'h00,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0040,1'b0,1'b1,8'hE5};
    tbl[5]  = '{1'b1,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,3'd0,16'h0040,1'b0,1'b1,8'h05};
    tbl[6]  = '{1'b1,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0040,1'b1,1'b1,8'hE5};
    tbl[7]  = '{1'b1,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,3'd0,16'h0040,1'b1,1'b1,8'hE5};
    tbl[8]  = '{1'b1,2'd0,8'h00,8'h00,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,3'd0,16'h0040,1'b0,1'b1,8'hE4};
    tbl[9]  = '{1'b1,2'd0,8'h00,8'h00,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0040,1'b0,1'b1,8'hE4};
    tbl[10] = '{1'b1,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0040,1'b0,1'b1,8'hE4};
    tbl[11] = '{1'b1,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0040,1'b1,1'b1,8'hE4};
    tbl[12] = '{1'b1,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,3'd2,16'h0050,1'b1,1'b1,8'hE4};
    tbl[13] = '{1'b1,2'd1,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd2,16'h0050,1'b1,1'b0,8'hE0};
    tbl[14] = '{1'b1,2'd1,8'h00,8'h02,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd2,16'h0050,1'b1,1'b0,8'hE2};
    tbl[15] = '{1'b1,2'd0,8'h00,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,3'd2,16'h0050,1'b0,1'b0,8'hE2};
    tbl[16] = '{1'b1,2'd0,8'h00,8'h00,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,3'd2,16'h0050,1'b0,1'b0,8'hE2};
    tbl[17] = '{1'b1,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd2,16'h0050,1'b0,1'b0,8'hE2};
    tbl[18] = '{1'b1,2'd0,8'h00,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,3'd2,16'h0050,1'b0,1'b0,8'hE2};
    tbl[19] = '{1'b1,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,3'd2,16'h0050,1'b0,1'b0,8'h05};
    tbl[20] = '{1'b1,2'd2,8'h04,8'h00,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,3'd2,16'h0050,1'b0,1'b0,8'h04};
    tbl[21] = '{1'b1,2'd0,8'h00,8'h04,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd2,16'h0050,1'b0,1'b1,8'hE6};
    tbl[22] = '{1'b1,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd2,16'h0050,1'b0,1'b1,8'hE6};
    tbl[23] = '{1'b1,2'd0,8'h00,8'h00,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,3'd2,16'h0050,1'b0,1'b1,8'hE6};
    tbl[24] = '{1'b1,2'd0,8'h00,8'h00,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,3'd2,16'h0050,1'b0,1'b1,8'hE6};
    tbl[25] = '{1'b1,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd2,16'h0050,1'b0,1'b1,8'hE6};
    tbl[26] = '{1'b1,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,3'd2,16'h0050,1'b1,1'b1,8'hE6};
    tbl[27] = '{1'b1,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,3'd2,16'h0050,1'b1,1'b1,8'hE6};
    tbl[28] = '{1'b1,2'd2,8'h05,8'h01,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,3'd2,16'h0050,1'b1,1'b1,8'hE7};
    tbl[29] = '{1'b1,2'd0,8'h00,8'h00,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,3'd2,16'h0050,1'b0,1'b1,8'hE3};

    for (int i = 0; i < 30; i++) apply_a(tbl[i], i);

    // Eight-source variant: highest index vector, then reset in the middle of the offer.
    step_b(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    step_b(1'b1, 2'd2, 8'h80, 8'h00, 1'b0, 1'b0);
    step_b(1'b1, 2'd0, 8'h00, 8'h80, 1'b0, 1'b0);
    step_b(1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    step_b(1'b1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    step_b(1'b1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("b_ime_armed", 100, {15'd0, ime_b}, 16'd1);
    chk("b_valid_before_boundary", 100, {15'd0, irq_valid_b}, 16'd0);
    step_b(1'b1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("b_irq_valid", 101, {15'd0, irq_valid_b}, 16'd1);
    chk("b_irq_index", 101, {13'd0, idx_b}, 16'd7);
    chk("b_irq_vector", 101, vec_b, 16'h00B0);
    chk("b_wake", 101, {15'd0, wake_b}, 16'd1);
    read_b(A_IF, rd);
    chk("b_rdata_IF", 101, {8'd0, rd}, 16'h0080);
    step_b(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("b_reset_valid", 102, {15'd0, irq_valid_b}, 16'd0);
    chk("b_reset_index", 102, {13'd0, idx_b}, 16'd0);
    chk("b_reset_vector", 102, vec_b, 16'h0040);
    chk("b_reset_ime", 102, {15'd0, ime_b}, 16'd0);
    read_b(A_IF, rd);
    chk("b_reset_IF", 102, {8'd0, rd}, 16'h0000);
    read_b(A_IE, rd);
    chk("b_reset_IE", 102, {8'd0, rd}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
